// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, IR field positions, default widths.
// Imported by the fetch unit and the branch-condition decoder.
package sisc_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 32;

  localparam int FLD_W   = 4;
  localparam int IMM_W   = 16;
  localparam int OP_LSB  = 28;
  localparam int MM_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    NOOP   = 4'h0,
    LOD    = 4'h1,
    STR    = 4'h2,
    SWP    = 4'h3,
    BRA    = 4'h4,
    BRR    = 4'h5,
    BNE    = 4'h6,
    BNR    = 4'h7,
    ALU_OP = 4'h8,
    HLT    = 4'hF
  } opcode_e;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition: masks status with mm and
// applies the taken/not-taken sense of the opcode.
module sisc_br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       br_taken
);

  logic hit;

  assign hit = |(stat & mm);

  always_comb begin
    br_taken = 1'b0;
    unique case (1'b1)
      (opcode == BRA) || (opcode == BRR):
        br_taken = hit;
      (opcode == BNE) || (opcode == BNR):
        br_taken = !hit;
      default:
        br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: PC, IR, status and halt flag with IR decode.
// Optional instruction counter enabled by SISC_INSTR_CNT_EN.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic               stat_en,
  input  logic [3:0]         alu_stat,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic [15:0]        imm,
  output logic [3:0]         stat,
`ifdef SISC_INSTR_CNT_EN
  output logic [31:0]        instr_cnt,
`endif
  output logic               br_taken,
  output logic               halted
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         stat_q, stat_d;
  logic               halted_q, halted_d;
  logic               ld_hlt;

  assign ld_hlt = ir_load &&
    (imem_data[OP_LSB +: FLD_W] == HLT);

  always_comb begin
    pc_d = pc_q;
    if (pc_write && !halted_q) begin
      unique case (1'b1)
        !pc_sel:
          pc_d = pc_q + PC_W'(1);
        pc_sel && !br_sel:
          pc_d = PC_W'(imm);
        default:
          pc_d = pc_q + PC_W'($signed(imm));
      endcase
    end
  end

  assign ir_d     = ir_load ? imem_data : ir_q;
  assign stat_d   = stat_en ? alu_stat : stat_q;
  assign halted_d = halted_q | ld_hlt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc_q     <= '0;
      ir_q     <= '0;
      stat_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      stat_q   <= stat_d;
      halted_q <= halted_d;
    end
  end

`ifdef SISC_INSTR_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // The HLT load itself is not counted; only work done before halting.
  assign cnt_d = (ir_load && !halted_d) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_cnt = cnt_q;
`endif

  assign imem_addr = pc_q;
  assign opcode    = ir_q[OP_LSB +: FLD_W];
  assign mm        = ir_q[MM_LSB +: FLD_W];
  assign rd        = ir_q[RD_LSB +: FLD_W];
  assign rs        = ir_q[RS_LSB +: FLD_W];
  assign rt        = ir_q[RT_LSB +: FLD_W];
  assign imm       = ir_q[IMM_LSB +: IMM_W];
  assign stat      = stat_q;
  assign halted    = halted_q;

  sisc_br_cond u_br_cond (
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat_q),
    .br_taken (br_taken)
  );

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Bench for sisc_fetch_unit: directed vector table, corner
// sequences and random stimulus against a behavioural model.
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f;
  logic        pc_write, pc_sel, br_sel, ir_load, stat_en;
  logic [3:0]  alu_stat;
  logic [31:0] imem_data;
  logic [15:0] imem_addr;
  logic [3:0]  opcode, mm, rd, rs, rt, stat;
  logic [15:0] imm;
  logic        br_taken, halted;
`ifdef SISC_INSTR_CNT_EN
  logic [31:0] instr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  sisc_fetch_unit dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .ir_load   (ir_load),
    .stat_en   (stat_en),
    .alu_stat  (alu_stat),
    .imem_data (imem_data),
    .imem_addr (imem_addr),
    .opcode    (opcode),
    .mm        (mm),
    .rd        (rd),
    .rs        (rs),
    .rt        (rt),
    .imm       (imm),
    .stat      (stat),
`ifdef SISC_INSTR_CNT_EN
    .instr_cnt (instr_cnt),
`endif
    .br_taken  (br_taken),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw, ps, bs, il, se;
    logic [3:0]  as;
    logic [31:0] data;
    logic [15:0] e_pc;
    logic [3:0]  e_op, e_stat;
    logic        e_br, e_halt;
  } vec_t;

  vec_t vt[18];

  // behavioural model state
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic [3:0]  m_stat;
  logic        m_halt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pw, ps, bs, il, se,
                       input logic [3:0] as, input logic [31:0] d);
    pc_write = pw; pc_sel = ps; br_sel = bs;
    ir_load = il; stat_en = se; alu_stat = as; imem_data = d;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_f = 1'b0;
    #2;
    rst_f = 1'b1;
    m_pc = '0; m_ir = '0; m_stat = '0; m_halt = 1'b0;
  endtask

  function automatic logic m_br(input logic [31:0] ir,
                                input logic [3:0] st);
    logic [3:0] o;
    logic       any;
    o   = ir[31:28];
    any = (st & ir[27:24]) != 4'h0;
    if (o == 4'd4 || o == 4'd5) return any;
    if (o == 4'd6 || o == 4'd7) return !any;
    return 1'b0;
  endfunction

  task automatic m_step(input logic pw, ps, bs, il, se,
                        input logic [3:0] as, input logic [31:0] d);
    logic [15:0] im;
    im = m_ir[15:0];
    if (pw && !m_halt) begin
      if (!ps)     m_pc = m_pc + 16'd1;
      else if (!bs) m_pc = im;
      else         m_pc = m_pc + im;
    end
    if (il) begin
      m_ir = d;
      if (d[31:28] == 4'hF) m_halt = 1'b1;
    end
    if (se) m_stat = as;
  endtask

  task automatic m_cmp(input string tag);
    chk({tag, ".pc"}, 32'(imem_addr), 32'(m_pc));
    chk({tag, ".op"}, 32'(opcode), 32'(m_ir[31:28]));
    chk({tag, ".mm"}, 32'(mm), 32'(m_ir[27:24]));
    chk({tag, ".imm"}, 32'(imm), 32'(m_ir[15:0]));
    chk({tag, ".stat"}, 32'(stat), 32'(m_stat));
    chk({tag, ".br"}, 32'(br_taken), 32'(m_br(m_ir, m_stat)));
    chk({tag, ".halt"}, 32'(halted), 32'(m_halt));
  endtask

  initial begin
    //        pw ps bs il se as     data           pc       op    st    br halt
    vt[0]  = '{1,0,0,0,0,4'h0,32'h0,        16'h0001,4'h0,4'h0,0,0};
    vt[1]  = '{1,0,0,0,0,4'h0,32'h0,        16'h0002,4'h0,4'h0,0,0};
    vt[2]  = '{1,0,0,0,0,4'h0,32'h0,        16'h0003,4'h0,4'h0,0,0};
    vt[3]  = '{0,0,0,1,0,4'h0,32'h0000_0002,16'h0003,4'h0,4'h0,0,0};
    vt[4]  = '{1,1,0,0,0,4'h0,32'h0,        16'h0002,4'h0,4'h0,0,0};
    vt[5]  = '{0,0,0,1,0,4'h0,32'h0000_FFFD,16'h0002,4'h0,4'h0,0,0};
    vt[6]  = '{1,1,1,0,0,4'h0,32'h0,        16'hFFFF,4'h0,4'h0,0,0};
    vt[7]  = '{1,0,0,0,0,4'h0,32'h0,        16'h0000,4'h0,4'h0,0,0};
    vt[8]  = '{0,0,0,0,1,4'h1,32'h0,        16'h0000,4'h0,4'h1,0,0};
    vt[9]  = '{0,0,0,1,0,4'h0,32'h4100_0000,16'h0000,4'h4,4'h1,1,0};
    vt[10] = '{0,0,0,1,0,4'h0,32'h6100_0000,16'h0000,4'h6,4'h1,0,0};
    vt[11] = '{0,0,0,1,0,4'h0,32'h6200_0000,16'h0000,4'h6,4'h1,1,0};
    vt[12] = '{0,0,0,1,1,4'hA,32'h5A00_0000,16'h0000,4'h5,4'hA,1,0};
    vt[13] = '{0,0,0,1,0,4'h0,32'h7400_0000,16'h0000,4'h7,4'hA,1,0};
    vt[14] = '{1,0,0,1,0,4'h0,32'h8000_0000,16'h0001,4'h8,4'hA,0,0};
    vt[15] = '{0,0,0,1,0,4'h0,32'hF000_0000,16'h0001,4'hF,4'hA,0,1};
    vt[16] = '{1,0,0,0,0,4'h0,32'h0,        16'h0001,4'hF,4'hA,0,1};
    vt[17] = '{1,1,0,1,0,4'h0,32'h0000_0030,16'h0001,4'h0,4'hA,0,1};

    idle();
    rst_f = 1'b0;
    #12;
    rst_f = 1'b1;
    chk("rst.pc", 32'(imem_addr), 32'h0);
    chk("rst.op", 32'(opcode), 32'h0);
    chk("rst.stat", 32'(stat), 32'h0);
    chk("rst.br", 32'(br_taken), 32'h0);
    chk("rst.halt", 32'(halted), 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].pw, vt[i].ps, vt[i].bs, vt[i].il, vt[i].se,
            vt[i].as, vt[i].data);
      cyc();
      chk($sformatf("v%0d.pc", i), 32'(imem_addr), 32'(vt[i].e_pc));
      chk($sformatf("v%0d.op", i), 32'(opcode), 32'(vt[i].e_op));
      chk($sformatf("v%0d.stat", i), 32'(stat), 32'(vt[i].e_stat));
      chk($sformatf("v%0d.br", i), 32'(br_taken), 32'(vt[i].e_br));
      chk($sformatf("v%0d.halt", i), 32'(halted), 32'(vt[i].e_halt));
    end

    // field decode
    idle();
    rst_pulse();
    drive(0, 0, 0, 1, 0, 4'h0, 32'h8ABC_1234);
    cyc();
    idle();
    chk("fld.mm", 32'(mm), 32'hA);
    chk("fld.rd", 32'(rd), 32'hB);
    chk("fld.rs", 32'(rs), 32'hC);
    chk("fld.rt", 32'(rt), 32'h1);
    chk("fld.imm", 32'(imm), 32'h1234);

    // async reset mid-cycle with PC=0x10, stat=A
    drive(0, 0, 0, 1, 1, 4'hA, 32'h0000_0010);
    cyc();
    drive(1, 1, 0, 0, 0, 4'h0, 32'h0);
    cyc();
    idle();
    chk("ar.pre.pc", 32'(imem_addr), 32'h10);
    chk("ar.pre.stat", 32'(stat), 32'hA);
    #2;
    rst_f = 1'b0;
    #1;
    chk("ar.pc", 32'(imem_addr), 32'h0);
    chk("ar.ir", {opcode, mm, rd, rs, imm}, 32'h0);
    chk("ar.stat", 32'(stat), 32'h0);
    chk("ar.halt", 32'(halted), 32'h0);
    @(negedge clk);
    rst_f = 1'b1;
    m_pc = '0; m_ir = '0; m_stat = '0; m_halt = 1'b0;

`ifdef SISC_INSTR_CNT_EN
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 0, 4'h0,
            (i == 5) ? 32'hF000_0000 : 32'h1000_0000);
      cyc();
    end
    idle();
    chk("cnt", instr_cnt, 32'd5);
    rst_pulse();
`endif

    // random against model
    for (int n = 0; n < 600; n++) begin
      logic pw, ps, bs, il, se;
      logic [3:0] as, op;
      logic [31:0] d;
      if ($urandom_range(0, 59) == 0 ||
          (m_halt && $urandom_range(0, 7) == 0)) begin
        idle();
        rst_pulse();
        cyc();
        m_cmp("rr");
      end
      pw = 1'($urandom_range(0, 1));
      ps = 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1));
      il = 1'($urandom_range(0, 1));
      se = 1'($urandom_range(0, 1));
      as = 4'($urandom_range(0, 15));
      op = ($urandom_range(0, 24) == 0) ? 4'hF
                                        : 4'($urandom_range(0, 8));
      d  = {op, 28'($urandom)};
      drive(pw, ps, bs, il, se, as, d);
      m_step(pw, ps, bs, il, se, as, d);
      cyc();
      m_cmp("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sisc_fetch_unit.md
# sisc_fetch_unit

Instruction-side companion to the SISC control FSM. It holds the program counter (PC), instruction register (IR) and status register. It decodes the IR into the `opcode`/`mm`/operand fields and evaluates the branch condition that the controller consumes. It acts only on strobes issued by the controller, so it forms the datapath end of the controller's opcode/status interface.

## Interface
Parameters:
- `PC_W`, 16: PC and instruction-address width.
- `INSTR_W`, 32: instruction word width.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_f` in 1: reset, asynchronous, active-low.
- `pc_write` in 1: update the PC this cycle.
- `pc_sel` in 1: PC source; 0 = PC+1, 1 = branch target.
- `br_sel` in 1: branch target mode; 0 = absolute `imm`, 1 = PC + `imm`.
- `ir_load` in 1: capture `imem_data` into the IR.
- `stat_en` in 1: capture `alu_stat` into the status register.
- `alu_stat` in 4: ALU flags {C,V,N,Z}.
- `imem_data` in INSTR_W: instruction word at `imem_addr`.
- `imem_addr` out PC_W: current PC; combinational from the PC register.
- `opcode` out 4: IR[31:28].
- `mm` out 4: IR[27:24].
- `rd`, `rs`, `rt` out 4 each: IR[23:20], IR[19:16], IR[15:12].
- `imm` out 16: IR[15:0].
- `stat` out 4: status register.
- `br_taken` out 1: branch condition for the current IR; combinational.
- `halted` out 1: set once an HLT instruction is loaded.

## Operation
- Reset (`rst_f` low), applied asynchronously:
  - PC = 0, IR = 0 (NOOP), `stat` = 0, `halted` = 0.
  - Every decoded output is therefore 0, and `br_taken` = 0.
- PC update when `pc_write` = 1 and `halted` = 0:
  - `pc_sel` = 0: PC ← PC+1.
  - `pc_sel` = 1, `br_sel` = 0: PC ← `imm`.
  - `pc_sel` = 1, `br_sel` = 1: PC ← PC + sign-extended `imm`.
  - All arithmetic is modulo 2^PC_W. 0xFFFF+1 wraps to 0x0000; 0x0002 + 0xFFFD gives 0xFFFF.
- `pc_write` is ignored while `halted` = 1; the PC holds.
- IR: when `ir_load` = 1, IR ← `imem_data`. The IR still loads when halted, but the PC is frozen.
- Status: when `stat_en` = 1, `stat` ← `alu_stat`. Otherwise `stat` holds.
- `br_taken` decode:
  - BRA (4) / BRR (5): 1 when (`stat` & `mm`) ≠ 0.
  - BNE (6) / BNR (7): 1 when (`stat` & `mm`) = 0.
  - Any other opcode: 0.
- `halted` is set on the edge on which `ir_load` = 1 and `imem_data`[31:28] = HLT (4'hF). It is cleared only by reset.
- The block does not gate `pc_write` with `br_taken`; qualifying the branch is the controller's job.

## Timing
- Every register output is valid on the cycle after its strobe edge.
- `opcode`, `mm`, `rd`, `rs`, `rt` and `imm` are combinational from the IR, so they are valid from the cycle after `ir_load`.
- `br_taken` is combinational from the IR and `stat`. It reflects a `stat_en` update one cycle after that update.
- `ir_load` and `pc_write` in the same cycle: the IR captures the word at the old PC, and `imem_addr` shows the new PC on the next cycle.
- `stat_en` and `ir_load` in the same cycle: both capture. `br_taken` on the next cycle uses the new IR and the new `stat`.
- `rst_f` asserted mid-operation: all state clears immediately, without waiting for a clock edge. The first capture after deassertion happens on the first rising edge with `rst_f` high.
- Memory assumption: `imem_data` is valid in the same cycle as `imem_addr` (zero-latency instruction ROM).

## Configuration
- `SISC_INSTR_CNT_EN` defined:
  - Adds output `instr_cnt` (32 bits, reset 0).
  - It increments on every `ir_load` edge while not halted, and wraps 0xFFFFFFFF→0.
- `SISC_INSTR_CNT_EN` undefined: the port and the counter are absent.

## Structure
- Shared package `sisc_pkg`:
  - Opcode constants: NOOP, LOD, STR, SWP, BRA, BRR, BNE, BNR, ALU_OP, HLT.
  - Field bit positions.
  - PC_W / INSTR_W defaults.
- One sub-module, `sisc_br_cond`: combinational; takes `opcode`, `mm`, `stat` and produces `br_taken`.
- The PC, IR, status register and halted flag live in the top module.

## Test plan
- Reset, then 3 cycles of `pc_write` = 1, `pc_sel` = 0 → `imem_addr` = 0,1,2,3; `opcode` = 0; `stat` = 0.
- PC = 0x0002, IR imm = 0xFFFD, `pc_sel` = 1, `br_sel` = 1 → PC = 0xFFFF. Follow with one PC+1 → 0x0000.
- `alu_stat` = 4'b0001 captured; load BRA with `mm` = 4'b0001 → `br_taken` = 1. Load BNE with `mm` = 4'b0001 → `br_taken` = 0. BNE with `mm` = 4'b0010 → 1.
- `ir_load` with 0xF0000000 → `halted` = 1, `opcode` = 4'hF. Further `pc_write` leaves PC unchanged until `rst_f` pulses low.
- Drop `rst_f` mid-cycle while PC = 0x0010 and `stat` = 4'hA → PC, IR, `stat` and `halted` read 0 before the next clock edge.
- With `SISC_INSTR_CNT_EN`: 5 `ir_load`s, then HLT, then 2 more `ir_load`s → `instr_cnt` = 5.
